// File: rtl/imem_loader_responder_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_responder_pkg
//   Shared constants for the instruction-memory responder / boot loader:
//   default widths, the NOP word handed to the core while it is held, the
//   loader FSM state encodings and a byte-lane insert helper.
// ---------------------------------------------------------------------------
package imem_loader_responder_pkg;

    localparam int          DEF_DATA_WIDTH           = 32;
    localparam int          DEF_MEM_ADDR_INSTR_WIDTH = 12;

    // addi x0, x0, 0
    localparam logic [31:0] DEF_NOP_WORD             = 32'h0000_0013;

    // Loader FSM encodings.
    localparam logic [1:0]  ST_RUN     = 2'd0;
    localparam logic [1:0]  ST_LOAD    = 2'd1;
    localparam logic [1:0]  ST_PAD     = 2'd2;
    localparam logic [1:0]  ST_RELEASE = 2'd3;

    // Place byte b into little-endian lane idx of word, leaving other lanes.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] res;
        res = word;
        res[8*idx +: 8] = b;
        return res;
    endfunction

endpackage

// File: rtl/imem_word_ram.sv
// ---------------------------------------------------------------------------
// imem_word_ram
//   Word-wide instruction RAM: one synchronous write port, one asynchronous
//   read port, contents are not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write word address
//   wdata_i  write data
//   raddr_i  read word address
//   rdata_o  read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module imem_word_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader_responder.sv
// ---------------------------------------------------------------------------
// imem_loader_responder
//   Instruction-memory responder for the IF-stage fetch port plus a byte
//   stream boot loader that fills the memory with little-endian words while
//   the core is held.
//
//   Loader handshake: a byte is transferred on a rising edge where
//   load_valid_i and load_ready_o are both high. load_ready_o is high only in
//   LOAD and does not depend on load_valid_i; load_last_i and load_data_i are
//   only looked at on a transfer.
//
// Ports:
//   clk                  clock
//   rst                  synchronous active-high reset
//   instruction_addr_i   fetch byte address (bits [1:0] ignored)
//   instruction_rdata_o  fetched word (NOP while the loader owns the memory)
//   boot_req_i           start a load session (honoured in RUN only)
//   load_valid_i         load byte valid
//   load_data_i          load byte
//   load_last_i          final byte of the image
//   load_ready_o         loader accepts a byte this cycle
//   core_hold_o          hold the core while not in RUN
//   load_err_o           sticky image-overflow flag
//   load_words_o         words written in the last/current session
// ---------------------------------------------------------------------------
module imem_loader_responder
    import imem_loader_responder_pkg::*;
#(
    parameter int          MEM_ADDR_INSTR_WIDTH = DEF_MEM_ADDR_INSTR_WIDTH,
    parameter int          DATA_WIDTH           = DEF_DATA_WIDTH,
    parameter logic [31:0] NOP_WORD             = DEF_NOP_WORD
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MEM_ADDR_INSTR_WIDTH-1:0] instruction_addr_i,
    output logic [DATA_WIDTH-1:0]           instruction_rdata_o,
    input  logic                            boot_req_i,
    input  logic                            load_valid_i,
    input  logic [7:0]                      load_data_i,
    input  logic                            load_last_i,
    output logic                            load_ready_o,
    output logic                            core_hold_o,
    output logic                            load_err_o,
    output logic [MEM_ADDR_INSTR_WIDTH-2:0] load_words_o
);

    localparam int WORD_AW = MEM_ADDR_INSTR_WIDTH - 2;

    logic [1:0]            state_q,    state_d;
    // One bit wider than the word index: the top bit set means the memory is full.
    logic [WORD_AW:0]      wptr_q,     wptr_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] asm_q,      asm_d;
    logic                  err_q,      err_d;
    logic [WORD_AW:0]      words_q,    words_d;

    logic [DATA_WIDTH-1:0] asm_next;
    logic                  commit;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  wptr_full;
    logic                  unused_addr_bits;

    assign wptr_full        = wptr_q[WORD_AW];
    assign unused_addr_bits = ^instruction_addr_i[1:0];

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        err_d      = err_q;
        words_d    = words_q;
        asm_next   = insert_byte(asm_q, byte_cnt_q, load_data_i);
        commit     = 1'b0;
        ram_we     = 1'b0;
        ram_wdata  = asm_q;

        case (state_q)
            ST_RUN: begin
                if (boot_req_i) begin
                    state_d    = ST_LOAD;
                    wptr_d     = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                    err_d      = 1'b0;
                    words_d    = '0;
                end
            end
            ST_LOAD: begin
                if (load_valid_i) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Word complete: write it and start the next one from zero
                        // so a later short tail is zero-padded.
                        commit    = 1'b1;
                        ram_wdata = asm_next;
                        asm_d     = '0;
                        if (load_last_i) begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        asm_d = asm_next;
                        if (load_last_i) begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                commit     = 1'b1;
                ram_wdata  = asm_q;
                asm_d      = '0;
                byte_cnt_d = '0;
                state_d    = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Once full, further words are dropped and flagged; the pointer and
        // word count stop at DEPTH.
        if (commit) begin
            if (wptr_full) begin
                err_d = 1'b1;
            end else begin
                ram_we  = 1'b1;
                wptr_d  = wptr_q + 1'b1;
                words_d = words_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wptr_q     <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            err_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

    imem_word_ram #(
        .AW (WORD_AW),
        .DW (DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wptr_q[WORD_AW-1:0]),
        .wdata_i (ram_wdata),
        .raddr_i (instruction_addr_i[MEM_ADDR_INSTR_WIDTH-1:2]),
        .rdata_o (ram_rdata)
    );

    assign instruction_rdata_o = (state_q == ST_RUN) ? ram_rdata : NOP_WORD;
    assign load_ready_o        = (state_q == ST_LOAD);
    assign core_hold_o         = (state_q != ST_RUN);
    assign load_err_o          = err_q;
    assign load_words_o        = words_q;

endmodule

// File: tb/tb_imem_loader_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_loader_responder
//   Directed bench for imem_loader_responder. A default-size instance covers
//   fetch, load, pad, gap and mid-session reset behaviour; a 4-word instance
//   covers image overflow. Inputs change 1 ns after the rising edge and
//   outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_imem_loader_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        boot_req;
    logic        boot_req_s;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;

    logic [11:0] addr;
    logic [31:0] rdata;
    logic        ready;
    logic        hold;
    logic        err;
    logic [10:0] words;

    logic [3:0]  addr_s;
    logic [31:0] rdata_s;
    logic        ready_s;
    logic        hold_s;
    logic        err_s;
    logic [2:0]  words_s;

    int errors;
    int checks;

    imem_loader_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .instruction_addr_i  (addr),
        .instruction_rdata_o (rdata),
        .boot_req_i          (boot_req),
        .load_valid_i        (load_valid),
        .load_data_i         (load_data),
        .load_last_i         (load_last),
        .load_ready_o        (ready),
        .core_hold_o         (hold),
        .load_err_o          (err),
        .load_words_o        (words)
    );

    imem_loader_responder #(.MEM_ADDR_INSTR_WIDTH(4)) dut_s (
        .clk                 (clk),
        .rst                 (rst),
        .instruction_addr_i  (addr_s),
        .instruction_rdata_o (rdata_s),
        .boot_req_i          (boot_req_s),
        .load_valid_i        (load_valid),
        .load_data_i         (load_data),
        .load_last_i         (load_last),
        .load_ready_o        (ready_s),
        .core_hold_o         (hold_s),
        .load_err_o          (err_s),
        .load_words_o        (words_s)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (hold !== 1'b0)  begin errors++; $display("FAIL reset_hold: got %b exp 0", hold); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready); end
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
        checks++; if (words !== 11'd0) begin errors++; $display("FAIL reset_words: got %0d exp 0", words); end
        checks++; if (hold_s !== 1'b0 || ready_s !== 1'b0) begin errors++; $display("FAIL reset_small: hold %b ready %b exp 0 0", hold_s, ready_s); end
        rst = 1'b0;
        step();
        checks++; if (hold !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL reset_idle: hold %b ready %b exp 0 0", hold, ready); end
    endtask

    task automatic test_load();
        logic [7:0] img [8];
        img = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        addr = 12'h000;
        boot_req = 1'b1;
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL load_hold_pre: got %b exp 0", hold); end
        step();
        boot_req = 1'b0;
        checks++; if (hold !== 1'b1)  begin errors++; $display("FAIL load_hold: got %b exp 1", hold); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b exp 1", ready); end
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_data  = img[i];
            load_last  = (i == 7);
            checks++; if (ready !== 1'b1 || rdata !== NOP) begin errors++; $display("FAIL load_byte%0d: ready %b rdata %h exp 1 %h", i, ready, rdata, NOP); end
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        // RELEASE
        checks++; if (hold !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL load_release: hold %b ready %b exp 1 0", hold, ready); end
        checks++; if (words !== 11'd2) begin errors++; $display("FAIL load_words: got %0d exp 2", words); end
        checks++; if (rdata !== NOP)   begin errors++; $display("FAIL load_release_rdata: got %h exp %h", rdata, NOP); end
        step();
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL load_run_hold: got %b exp 0", hold); end
        checks++; if (rdata !== 32'h0050_0093) begin errors++; $display("FAIL load_run_rdata: got %h exp 00500093", rdata); end
    endtask

    task automatic test_fetch();
        logic [11:0] a [4];
        logic [31:0] e [4];
        a = '{12'h000, 12'h002, 12'h004, 12'h007};
        e = '{32'h0050_0093, 32'h0050_0093, 32'h00A0_0113, 32'h00A0_0113};
        for (int i = 0; i < 4; i++) begin
            addr = a[i];
            #1;
            checks++; if (rdata !== e[i]) begin errors++; $display("FAIL fetch_%h: got %h exp %h", a[i], rdata, e[i]); end
        end
        addr = 12'h000;
        step();
    endtask

    task automatic test_partial();
        boot_req = 1'b1;
        step();
        boot_req   = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hAA;
        load_last  = 1'b0;
        step();
        load_data  = 8'hBB;
        load_last  = 1'b1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        // PAD
        checks++; if (ready !== 1'b0 || hold !== 1'b1) begin errors++; $display("FAIL pad_state: ready %b hold %b exp 0 1", ready, hold); end
        checks++; if (words !== 11'd0) begin errors++; $display("FAIL pad_words: got %0d exp 0", words); end
        step();
        // RELEASE
        checks++; if (words !== 11'd1 || ready !== 1'b0 || hold !== 1'b1) begin errors++; $display("FAIL pad_release: words %0d ready %b hold %b exp 1 0 1", words, ready, hold); end
        step();
        addr = 12'h000;
        #1;
        checks++; if (rdata !== 32'h0000_BBAA) begin errors++; $display("FAIL pad_word0: got %h exp 0000bbaa", rdata); end
        addr = 12'h004;
        #1;
        checks++; if (rdata !== 32'h00A0_0113) begin errors++; $display("FAIL pad_word1: got %h exp 00a00113", rdata); end
        addr = 12'h000;
    endtask

    task automatic test_gaps();
        logic [7:0] b [4];
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        boot_req = 1'b1;
        step();
        boot_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = b[i];
            load_last  = (i == 3);
            step();
            if (i < 3) begin
                // Idle cycle with junk on data/last that must be ignored.
                load_valid = 1'b0;
                load_data  = 8'hFF;
                load_last  = 1'b1;
                checks++; if (ready !== 1'b1 || words !== 11'd0) begin errors++; $display("FAIL gap%0d: ready %b words %0d exp 1 0", i, ready, words); end
                step();
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        checks++; if (words !== 11'd1 || ready !== 1'b0) begin errors++; $display("FAIL gap_release: words %0d ready %b exp 1 0", words, ready); end
        step();
        addr = 12'h000;
        #1;
        checks++; if (rdata !== 32'h4433_2211) begin errors++; $display("FAIL gap_word0: got %h exp 44332211", rdata); end
    endtask

    task automatic test_overflow();
        logic [3:0]  a [4];
        logic [31:0] e [4];
        a = '{4'h0, 4'h4, 4'h8, 4'hC};
        e = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};
        boot_req_s = 1'b1;
        step();
        boot_req_s = 1'b0;
        checks++; if (hold_s !== 1'b1 || err_s !== 1'b0 || words_s !== 3'd0) begin errors++; $display("FAIL ovf_start: hold %b err %b words %0d exp 1 0 0", hold_s, err_s, words_s); end
        for (int i = 0; i < 20; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i + 1);
            load_last  = (i == 19);
            checks++; if (ready_s !== 1'b1) begin errors++; $display("FAIL ovf_ready%0d: got %b exp 1", i, ready_s); end
            step();
            if (i == 15) begin
                checks++; if (words_s !== 3'd4 || err_s !== 1'b0) begin errors++; $display("FAIL ovf_full: words %0d err %b exp 4 0", words_s, err_s); end
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        checks++; if (err_s !== 1'b1 || words_s !== 3'd4 || ready_s !== 1'b0) begin errors++; $display("FAIL ovf_release: err %b words %0d ready %b exp 1 4 0", err_s, words_s, ready_s); end
        step();
        for (int i = 0; i < 4; i++) begin
            addr_s = a[i];
            #1;
            checks++; if (rdata_s !== e[i]) begin errors++; $display("FAIL ovf_word%0d: got %h exp %h", i, rdata_s, e[i]); end
        end
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", err_s); end
        boot_req_s = 1'b1;
        step();
        boot_req_s = 1'b0;
        checks++; if (err_s !== 1'b0 || words_s !== 3'd0) begin errors++; $display("FAIL ovf_clear: err %b words %0d exp 0 0", err_s, words_s); end
        load_valid = 1'b1;
        load_data  = 8'h5A;
        load_last  = 1'b1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        step();
        step();
        addr_s = 4'h0;
        #1;
        checks++; if (rdata_s !== 32'h0000_005A || words_s !== 3'd1 || err_s !== 1'b0) begin errors++; $display("FAIL ovf_reload: rdata %h words %0d err %b exp 0000005a 1 0", rdata_s, words_s, err_s); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b [6];
        b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
        boot_req = 1'b1;
        step();
        boot_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load_valid = 1'b1;
            load_data  = b[i];
            load_last  = 1'b0;
            step();
        end
        load_valid = 1'b0;
        checks++; if (words !== 11'd1 || hold !== 1'b1) begin errors++; $display("FAIL mid_pre: words %0d hold %b exp 1 1", words, hold); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (hold !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL mid_state: hold %b ready %b exp 0 0", hold, ready); end
        checks++; if (words !== 11'd0 || err !== 1'b0) begin errors++; $display("FAIL mid_regs: words %0d err %b exp 0 0", words, err); end
        addr = 12'h000;
        #1;
        checks++; if (rdata !== 32'hEFBE_ADDE) begin errors++; $display("FAIL mid_word0: got %h exp efbeadde", rdata); end
        addr = 12'h004;
        #1;
        checks++; if (rdata !== 32'h00A0_0113) begin errors++; $display("FAIL mid_word1: got %h exp 00a00113", rdata); end
        step();
        checks++; if (hold !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL mid_idle: hold %b ready %b exp 0 0", hold, ready); end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        boot_req   = 1'b0;
        boot_req_s = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        addr       = 12'h000;
        addr_s     = 4'h0;

        test_reset();
        test_load();
        test_fetch();
        test_partial();
        test_gaps();
        test_overflow();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
